qspi_flash_read_seq: RTL

//  Single-lane SPI read sequencer for the s25fl256s boot flash on the qspi_* pins.

---
 rtl/qspi_flash_read_seq.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/qspi_flash_read_seq.sv
// Single-lane SPI (mode 0) read sequencer for the boot flash.
// One request becomes one framed READ: command, address, 32 data bits.
`timescale 1ns/1ps
module qspi_flash_read_seq #(
  parameter int         CLK_DIV   = 2,
  parameter logic [7:0] CMD       = 8'h13,
  parameter int         ADDR_BITS = 32,
  parameter int         CS_SETUP  = 1,
  parameter int         CS_DESEL  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        busy,
  output logic        qspi_cs,
  output logic        qspi_sck,
  output logic        qspi_dq_0,
  input  logic        qspi_dq_1
);

  localparam int HW   = 8 + ADDR_BITS;
  localparam int NB   = HW + 32;
  localparam int BW   = $clog2(NB);
  localparam int M1   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int CMAX = (M1 > CS_DESEL) ? M1 : CS_DESEL;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, HOLD, DESEL
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic            sck_q, sck_d;
  logic            cs_q, cs_d;
  logic [HW-1:0]   sh_q, sh_d;
  logic [31:0]     rx_q, rx_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sck_q    <= 1'b0;
      cs_q     <= 1'b1;
      sh_q     <= '0;
      rx_q     <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sck_q    <= sck_d;
      cs_q     <= cs_d;
      sh_q     <= sh_d;
      rx_q     <= rx_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sck_d    = sck_q;
    cs_d     = cs_q;
    sh_d     = sh_q;
    rx_d     = rx_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = SETUP;
          cs_d    = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
          sh_d    = {CMD, req_addr[ADDR_BITS-1:0]};
        end
      end
      SETUP: begin
        if (cnt_q == CW'(CS_SETUP - 1)) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SHIFT: begin
        if (cnt_q == CW'(CLK_DIV - 1)) begin
          cnt_d = '0;
          sck_d = !sck_q;
          // Rising edge samples MISO; falling edge advances MOSI.
          if (!sck_q) begin
            if (bit_q >= BW'(HW))
              rx_d = {rx_q[30:0], qspi_dq_1};
          end else begin
            sh_d = {sh_q[HW-2:0], 1'b0};
            if (bit_q == BW'(NB - 1))
              state_d = HOLD;
            else
              bit_d = bit_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        state_d  = DESEL;
        cs_d     = 1'b1;
        cnt_d    = '0;
        rvalid_d = 1'b1;
        rdata_d  = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
      end
      DESEL: begin
        if (cnt_q == CW'(CS_DESEL - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready  = (state_q == IDLE) && !rst;
  assign busy       = (state_q != IDLE);
  assign qspi_cs    = cs_q;
  assign qspi_sck   = sck_q;
  assign qspi_dq_0  = sh_q[HW-1];
  assign resp_valid = rvalid_q;
  assign resp_data  = rdata_q;

endmodule
